branch_pc_unit: RTL and testbench

- Program-counter register plus branch-commit sequencer for the datapath.
- Sits directly downstream of the CON flip-flop logic and consumes its registered conditionMet flag.
- On a branch instruction, the control unit pulses brStart after CONin fires. This block samples conditionMet once it has settled, then either redirects PC to PC + sign-extended C offset or leaves PC unchanged.
- Also provides the normal fetch increment, bus load of PC and saturating taken/not-taken statistics.

---
 rtl/branch_pc_pkg.sv | 17 +
 rtl/branch_pc_if.sv | 31 +++
 rtl/branch_pc_unit_sat_counter.sv | 21 ++
 rtl/branch_pc_unit.sv | 96 +++++++++
 tb/tb_branch_pc_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/branch_pc_pkg.sv
// rtl/branch_pc_pkg.sv - shared widths, branch FSM encoding and sign-extend helper
package branch_pc_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int OFF_W_DEF  = 19;

   localparam logic [1:0] BR_IDLE   = 2'd0;
   localparam logic [1:0] BR_SETTLE = 2'd1;
   localparam logic [1:0] BR_SAMPLE = 2'd2;
   localparam logic [1:0] BR_COMMIT = 2'd3;

   // Shared with the immediate path: two's complement C field to a full word.
   function automatic logic [DATA_W_DEF-1:0] sext_off(input logic [OFF_W_DEF-1:0] off);
      return {{(DATA_W_DEF-OFF_W_DEF){off[OFF_W_DEF-1]}}, off};
   endfunction

endpackage

// File: rtl/branch_pc_if.sv
// rtl/branch_pc_if.sv - control/datapath bundle between sequencer and PC unit
interface branch_pc_if
   import branch_pc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OFF_W  = OFF_W_DEF,
   parameter int CNT_W  = 16
);
   logic [DATA_W-1:0] busMuxOut;
   logic              PCin;
   logic              IncPC;
   logic              brStart;
   logic [OFF_W-1:0]  brOffset;
   logic              conditionMet;
   logic [DATA_W-1:0] pcOut;
   logic              brBusy;
   logic              brDone;
   logic              brTaken;
   logic [CNT_W-1:0]  takenCnt;
   logic [CNT_W-1:0]  notTakenCnt;

   modport master (
      output busMuxOut, PCin, IncPC, brStart, brOffset, conditionMet,
      input  pcOut, brBusy, brDone, brTaken, takenCnt, notTakenCnt
   );

   modport slave (
      input  busMuxOut, PCin, IncPC, brStart, brOffset, conditionMet,
      output pcOut, brBusy, brDone, brTaken, takenCnt, notTakenCnt
   );
endinterface

// File: rtl/branch_pc_unit_sat_counter.sv
// rtl/branch_pc_unit_sat_counter.sv - saturating up-counter for branch statistics
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;
endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - PC register with four-phase branch commit and taken statistics
module branch_pc_unit
   import branch_pc_pkg::*;
#(
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                OFF_W    = OFF_W_DEF,
   parameter int                CNT_W    = 16,
   parameter logic [DATA_W-1:0] RESET_PC = '0
) (
   input  logic     clock,
   input  logic     clear,
   branch_pc_if.slave bif
);
   typedef enum logic [1:0] {
      ST_IDLE   = BR_IDLE,
      ST_SETTLE = BR_SETTLE,
      ST_SAMPLE = BR_SAMPLE,
      ST_COMMIT = BR_COMMIT
   } br_state_e;

   br_state_e         state_q;
   logic [DATA_W-1:0] pc_q;
   logic [OFF_W-1:0]  off_q;
   logic              take_q;
   logic              taken_q;
   logic              done_q;
   logic [DATA_W-1:0] target_d;
   logic              commit_d;
   logic              inc_taken_d;
   logic              inc_not_taken_d;

   assign target_d        = pc_q + sext_off(off_q);
   // A PCin on the commit edge aborts, so the statistics must not move either.
   assign commit_d        = (state_q == ST_COMMIT) && !bif.PCin;
   assign inc_taken_d     = commit_d && take_q;
   assign inc_not_taken_d = commit_d && !take_q;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         off_q   <= '0;
         take_q  <= 1'b0;
         taken_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bif.PCin) begin
            pc_q    <= bif.busMuxOut;
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (bif.brStart) begin
                     off_q   <= bif.brOffset;
                     state_q <= ST_SETTLE;
                  end else if (bif.IncPC) begin
                     pc_q <= pc_q + 1'b1;
                  end
               end
               ST_SETTLE: state_q <= ST_SAMPLE;
               ST_SAMPLE: begin
                  take_q  <= bif.conditionMet;
                  state_q <= ST_COMMIT;
               end
               ST_COMMIT: begin
                  if (take_q) pc_q <= target_d;
                  taken_q <= take_q;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
      .clock (clock),
      .clear (clear),
      .inc   (inc_taken_d),
      .count (bif.takenCnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_not_taken_cnt (
      .clock (clock),
      .clear (clear),
      .inc   (inc_not_taken_d),
      .count (bif.notTakenCnt)
   );

   assign bif.pcOut   = pc_q;
   assign bif.brBusy  = (state_q != ST_IDLE);
   assign bif.brDone  = done_q;
   assign bif.brTaken = taken_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard bench for branch_pc_unit
module tb_branch_pc_unit;

   logic clock = 1'b0;
   logic clear = 1'b1;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic [15:0] tc;
      logic [15:0] nc;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] exp_tc = '0;
   logic [15:0] exp_nc = '0;

   always #5 clock = ~clock;

   branch_pc_if #(.DATA_W(32), .OFF_W(19), .CNT_W(16)) bus_if ();

   branch_pc_unit #(.DATA_W(32), .OFF_W(19), .CNT_W(16), .RESET_PC(32'h0)) dut (
      .clock (clock),
      .clear (clear),
      .bif   (bus_if)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every commit pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      if (!clear && bus_if.brDone === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_brDone", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("commit_pc", bus_if.pcOut, e.pc);
            chk("commit_taken", {31'd0, bus_if.brTaken}, {31'd0, e.taken});
            chk("commit_taken_cnt", {16'd0, bus_if.takenCnt}, {16'd0, e.tc});
            chk("commit_not_taken_cnt", {16'd0, bus_if.notTakenCnt}, {16'd0, e.nc});
         end
      end
   end

   task automatic load_pc(input logic [31:0] v);
      @(negedge clock);
      bus_if.PCin      = 1'b1;
      bus_if.busMuxOut = v;
      @(negedge clock);
      bus_if.PCin      = 1'b0;
   endtask

   task automatic run_branch(input logic [18:0] off, input logic cond_settle,
                             input logic cond_sample, input logic inc_settle,
                             input logic [31:0] exp_pc);
      exp_t e;
      if (cond_sample) begin
         if (exp_tc != 16'hFFFF) exp_tc++;
      end else if (exp_nc != 16'hFFFF) begin
         exp_nc++;
      end
      e.pc = exp_pc; e.taken = cond_sample; e.tc = exp_tc; e.nc = exp_nc;
      sb_q.push_back(e);
      @(negedge clock);
      bus_if.brStart  = 1'b1;
      bus_if.brOffset = off;
      @(negedge clock);
      bus_if.brStart      = 1'b0;
      bus_if.conditionMet = cond_settle;
      bus_if.IncPC        = inc_settle;
      chk("busy_settle", {31'd0, bus_if.brBusy}, 32'd1);
      @(negedge clock);
      bus_if.conditionMet = cond_sample;
      bus_if.IncPC        = 1'b0;
      chk("busy_sample", {31'd0, bus_if.brBusy}, 32'd1);
      @(negedge clock);
      bus_if.conditionMet = ~cond_sample;
      chk("busy_commit", {31'd0, bus_if.brBusy}, 32'd1);
      @(negedge clock);
      bus_if.conditionMet = 1'b0;
      chk("busy_after_commit", {31'd0, bus_if.brBusy}, 32'd0);
      chk("done_high", {31'd0, bus_if.brDone}, 32'd1);
      @(negedge clock);
      chk("done_one_cycle", {31'd0, bus_if.brDone}, 32'd0);
   endtask

   initial begin
      bus_if.busMuxOut    = '0;
      bus_if.PCin         = 1'b0;
      bus_if.IncPC        = 1'b0;
      bus_if.brStart      = 1'b0;
      bus_if.brOffset     = '0;
      bus_if.conditionMet = 1'b0;

      @(negedge clock);
      clear = 1'b0;
      chk("reset_pc", bus_if.pcOut, 32'h0);
      chk("reset_busy", {31'd0, bus_if.brBusy}, 32'd0);
      chk("reset_done", {31'd0, bus_if.brDone}, 32'd0);
      chk("reset_taken", {31'd0, bus_if.brTaken}, 32'd0);

      // Count up, then clear mid-cycle and expect reset values before any edge.
      bus_if.IncPC = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #2 clear = 1'b1;
      #1;
      chk("async_clear_pc", bus_if.pcOut, 32'h0);
      chk("async_clear_busy", {31'd0, bus_if.brBusy}, 32'd0);
      chk("async_clear_cnt", {bus_if.takenCnt, bus_if.notTakenCnt}, 32'h0);
      @(negedge clock);
      clear = 1'b0;
      bus_if.IncPC = 1'b1;
      repeat (3) @(negedge clock);
      bus_if.IncPC = 1'b0;
      chk("inc_three", bus_if.pcOut, 32'h3);

      load_pc(32'h10);
      run_branch(19'h00005, 1'b1, 1'b1, 1'b0, 32'h15);
      load_pc(32'h2);
      run_branch(19'h7FFFC, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
      // Condition true only in SETTLE, IncPC in SETTLE: both must be ignored.
      load_pc(32'h40);
      run_branch(19'h00010, 1'b1, 1'b0, 1'b1, 32'h40);

      // Abort in SAMPLE via PCin.
      load_pc(32'h80);
      @(negedge clock);
      bus_if.brStart = 1'b1; bus_if.brOffset = 19'h5; bus_if.conditionMet = 1'b1;
      @(negedge clock);
      bus_if.brStart = 1'b0;
      @(negedge clock);
      bus_if.PCin = 1'b1; bus_if.busMuxOut = 32'h1234;
      @(negedge clock);
      bus_if.PCin = 1'b0; bus_if.conditionMet = 1'b0;
      chk("abort_pc", bus_if.pcOut, 32'h1234);
      chk("abort_busy", {31'd0, bus_if.brBusy}, 32'd0);
      repeat (2) @(negedge clock);
      chk("abort_no_done", {31'd0, bus_if.brDone}, 32'd0);
      chk("abort_cnt", {bus_if.takenCnt, bus_if.notTakenCnt}, {16'd2, 16'd1});

      // PCin and brStart together in IDLE: load wins, no branch.
      @(negedge clock);
      bus_if.PCin = 1'b1; bus_if.busMuxOut = 32'h55; bus_if.brStart = 1'b1;
      @(negedge clock);
      bus_if.PCin = 1'b0; bus_if.brStart = 1'b0;
      chk("pcin_vs_brstart_pc", bus_if.pcOut, 32'h55);
      chk("pcin_vs_brstart_busy", {31'd0, bus_if.brBusy}, 32'd0);

      // Clear during an in-flight branch abandons it.
      @(negedge clock);
      bus_if.brStart = 1'b1; bus_if.brOffset = 19'h3; bus_if.conditionMet = 1'b1;
      @(negedge clock);
      bus_if.brStart = 1'b0;
      @(posedge clock);
      #2 clear = 1'b1;
      #1;
      chk("clear_inflight_busy", {31'd0, bus_if.brBusy}, 32'd0);
      chk("clear_inflight_cnt", {bus_if.takenCnt, bus_if.notTakenCnt}, 32'h0);
      @(negedge clock);
      clear = 1'b0;
      bus_if.conditionMet = 1'b0;
      exp_tc = '0;
      exp_nc = '0;

      // Saturation from a preloaded near-max taken count.
      @(negedge clock);
      force dut.u_taken_cnt.count_q = 16'hFFFE;
      @(negedge clock);
      release dut.u_taken_cnt.count_q;
      exp_tc = 16'hFFFE;
      run_branch(19'h1, 1'b1, 1'b1, 1'b0, 32'h1);
      run_branch(19'h1, 1'b1, 1'b1, 1'b0, 32'h2);
      run_branch(19'h1, 1'b1, 1'b1, 1'b0, 32'h3);

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clock);
      chk("scoreboard_drained", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
